// File: rtl/spi_pkg.sv
// Shared SPI link constants and types: mode, default word width, slave FSM
// encoding and the minimum clk/sclk ratio both ends of the link rely on.
package spi_pkg;

    localparam int SPI_CPOL           = 0;
    localparam int SPI_CPHA           = 0;
    localparam int SPI_MODE           = 0;
    localparam int SPI_MSB_FIRST      = 1;
    localparam int SPI_DEFAULT_DATA_W = 8;
    localparam int SPI_MIN_CLK_RATIO  = 8;

    typedef enum logic [1:0] {
        SPI_IDLE  = 2'd0,
        SPI_LOAD  = 2'd1,
        SPI_SHIFT = 2'd2
    } spi_state_e;

    function automatic int spi_cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses taken from the last stage against one extra flop.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Reset to the pin's idle level so leaving reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 target, oversampled in the clk domain, with rx strobe and a tx
// holding register. SPI_SLAVE_STATUS_EN adds sticky overrun/underrun flags.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                DATA_W      = SPI_DEFAULT_DATA_W,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_BYTE   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
`ifdef SPI_SLAVE_STATUS_EN
    input  logic              rx_ack,
    input  logic              status_clr,
    output logic              rx_overrun,
    output logic              tx_underrun,
`endif
    output logic [1:0]        dbg_state
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_W  = spi_cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] S_IDLE  = SPI_IDLE;
    localparam logic [1:0] S_LOAD  = SPI_LOAD;
    localparam logic [1:0] S_SHIFT = SPI_SHIFT;

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;

    logic              w_sclk_lvl_unused;
    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_cs_q;
    logic              w_cs_rise;
    logic              w_cs_fall;
    logic              w_mosi_q;
    logic              w_mosi_rise_unused;
    logic              w_mosi_fall_unused;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rx_shift;
    logic [DATA_W-1:0] r_tx_shift;
    logic              r_miso;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic [DATA_W-1:0] r_hold;
    logic              r_hold_full;

    logic [DATA_W-1:0] w_rx_word;
    logic [DATA_W-1:0] w_load_word;
    logic              w_load_now;
    logic              w_word_done;

    // Reset asserts asynchronously but releases on a clk edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    spi_sync_edge #(.STAGES(SYNC_N), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rst_n  (w_rst_n),
        .i_d    (sclk),
        .o_q    (w_sclk_lvl_unused),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_N), .RESET_VAL(1'b1)) u_sync_cs (
        .clk    (clk),
        .rst_n  (w_rst_n),
        .i_d    (cs_n),
        .o_q    (w_cs_q),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_N), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst_n  (w_rst_n),
        .i_d    (mosi),
        .o_q    (w_mosi_q),
        .o_rise (w_mosi_rise_unused),
        .o_fall (w_mosi_fall_unused)
    );

    assign w_rx_word   = {r_rx_shift[DATA_W-2:0], w_mosi_q};
    assign w_load_word = r_hold_full ? r_hold : IDLE_BYTE;

    // The fall after a word's last rise (counter wrapped to 0) refills the
    // tx shifter, so words stream without a cs_n toggle.
    assign w_load_now  = !w_cs_rise &&
                         ((r_state == S_LOAD) ||
                          ((r_state == S_SHIFT) && w_sclk_fall && (r_cnt == '0)));
    assign w_word_done = !w_cs_rise && (r_state == S_SHIFT) && w_sclk_rise &&
                         (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_miso     <= 1'b0;
        end else if (w_cs_rise) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_miso  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_tx_shift <= w_load_word;
                    r_miso     <= w_load_word[DATA_W-1];
                    r_cnt      <= '0;
                    r_state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (w_sclk_rise) begin
                        r_rx_shift <= w_rx_word;
                        r_cnt      <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
                    end else if (w_sclk_fall) begin
                        if (r_cnt == '0) begin
                            r_tx_shift <= w_load_word;
                            r_miso     <= w_load_word[DATA_W-1];
                        end else begin
                            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                            r_miso     <= r_tx_shift[DATA_W-2];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A pending word survives a cs_n abort; only the shifter consuming it empties the register.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_load_now && r_hold_full) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (tx_valid && !r_hold_full) begin
            r_hold      <= tx_data;
            r_hold_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            if (w_word_done) begin
                r_rx_data <= w_rx_word;
            end
`ifdef SPI_SLAVE_STATUS_EN
            if (w_word_done) begin
                r_rx_valid <= 1'b1;
            end else if (rx_ack) begin
                r_rx_valid <= 1'b0;
            end
`else
            r_rx_valid <= w_word_done;
`endif
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    logic r_rx_overrun;
    logic r_tx_underrun;

    // A new set event in the same cycle as status_clr wins, so no event is lost.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_overrun  <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            if (status_clr) begin
                r_rx_overrun  <= 1'b0;
                r_tx_underrun <= 1'b0;
            end
            if (w_word_done && r_rx_valid && !rx_ack) begin
                r_rx_overrun <= 1'b1;
            end
            if (w_load_now && !r_hold_full) begin
                r_tx_underrun <= 1'b1;
            end
        end
    end

    assign rx_overrun  = r_rx_overrun;
    assign tx_underrun = r_tx_underrun;
`endif

    assign miso      = r_miso;
    assign miso_oe   = (r_state != S_IDLE);
    assign tx_ready  = ~r_hold_full;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign busy      = ~w_cs_q;
    assign dbg_state = r_state;

endmodule
